gpio_edge_irq: RTL and testbench
================================

GPIO_EDGE_IRQ -- requirements
Module: gpio_edge_irq

Interface
REQ-001 Parameter ADDR_WIDTH, default 4, SHALL be the bus address offset width.
REQ-002 Parameter DATA_WIDTH, default 32, SHALL be the bus data width.
REQ-003 Parameter GPIO_WIDTH, default 4, SHALL be the number of monitored pins.
REQ-004 Parameter DEBOUNCE_CYCLES, default 4, range 1..255, SHALL be the stability window in clk cycles.
REQ-005 clk  input  1  SHALL be the sole clock; all state updates on its rising edge.
REQ-006 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-007 i_sel  input  1  SHALL be the chip select.
REQ-008 i_we  input  1  SHALL be the write enable.
REQ-009 i_addr  input  ADDR_WIDTH  SHALL be the register offset.
REQ-010 i_wdata  input  DATA_WIDTH  SHALL be the CPU write data.
REQ-011 o_rdata  output  DATA_WIDTH  SHALL be the combinational readback.
REQ-012 i_pins  input  GPIO_WIDTH  SHALL be the raw asynchronous pin levels, read from the same pads the GPIO register block drives.
REQ-013 o_irq  output  1  SHALL be the level interrupt to the CPU.

Function
REQ-014 Each i_pins bit SHALL pass through a two-flop synchronizer (sync1, sync2) before any other use.
REQ-015 Per pin, while sync2 differs from debounced state, a counter SHALL increment each cycle; when sync2 equals debounced state, it SHALL clear to 0.
REQ-016 On the cycle the counter equals DEBOUNCE_CYCLES-1 and sync2 still differs, debounced state SHALL take sync2 and the counter SHALL clear.
REQ-017 A pin level held stable SHALL appear in debounced state exactly 2+DEBOUNCE_CYCLES rising edges after it is first sampled by sync1.
REQ-018 A sync2 pulse shorter than DEBOUNCE_CYCLES cycles SHALL leave debounced state and STATUS unchanged.
REQ-019 Register map: 0x0 STATE (RO, debounced levels); 0x4 RISE_EN (RW); 0x8 FALL_EN (RW); 0xC STATUS (RW1C).
REQ-020 A debounced 0->1 transition with RISE_EN[i]=1, or a debounced 1->0 transition with FALL_EN[i]=1, SHALL set STATUS[i] on the same edge that debounced state updates.
REQ-021 A write to STATUS SHALL clear each bit written as 1 and leave bits written as 0 unchanged.
REQ-022 A set event and a W1C clear on the same bit in the same cycle SHALL leave the bit set.
REQ-023 Writing RISE_EN or FALL_EN SHALL NOT modify STATUS.
REQ-024 o_irq SHALL equal the OR of all STATUS bits, derived from registers only.
REQ-025 Reads (i_sel=1, i_we=0) SHALL return the addressed register zero-extended to DATA_WIDTH.
REQ-026 Reads of unmapped offsets, and o_rdata whenever no read is active, SHALL be 0.
REQ-027 Writes to STATE or to unmapped offsets SHALL have no effect.
REQ-028 Write data bits above GPIO_WIDTH-1 SHALL be ignored.

Reset
REQ-029 On a clk edge with reset=1, sync1, sync2, debounced state, counters, RISE_EN, FALL_EN and STATUS SHALL clear to 0; o_irq SHALL be 0 after that edge.
REQ-030 Reset asserted mid-debounce SHALL discard the partial count, with no STATUS set.
REQ-031 A pin high at reset release SHALL produce a debounced rising transition, setting STATUS only if RISE_EN was written beforehand.

Structure
REQ-032 Register offsets (STATE, RISE_EN, FALL_EN, STATUS) SHALL be defined in shared package gpio_pkg, alongside the GPIO register block's offsets.
REQ-033 Synchronizer, counter and debounced flop for one pin SHALL be sub-module gpio_debounce_bit, instantiated GPIO_WIDTH times via generate.
REQ-034 Counter width SHALL be sized from DEBOUNCE_CYCLES at elaboration.

Verification (GPIO_WIDTH=4, DEBOUNCE_CYCLES=4)
REQ-035 Reset, then i_pins=4'b0101 held -> STATE reads 0x5 after edge 6, and reads 0x0 at edge 5.
REQ-036 RISE_EN=0x1, then pin0 0->1 held -> STATUS=0x1 and o_irq=1 six edges later; write STATUS=0x1 -> STATUS=0x0, o_irq=0.
REQ-037 FALL_EN=0x2, then pin1 pulsed high for 3 cycles -> STATE and STATUS unchanged; pin1 high for 10 cycles then low -> STATUS=0x2 only after the fall.
REQ-038 STATUS=0x1 pending; W1C of 0x1 in the same cycle pin0 sets again -> STATUS bit 0 remains 1.
REQ-039 Reset asserted at counter=2 during a pin3 rise -> STATUS=0x0; STATE bit 3 updates only after 6 edges measured from reset release.
REQ-040 Read offset 0x4 while i_sel=0, and read offset 0x10 -> o_rdata=0; write 0xFFFFFFFF to RISE_EN -> reads 0x0000000F.

Source files
------------

// File: rtl/gpio_pkg.sv
// rtl/gpio_pkg.sv - shared GPIO register offsets and edge-IRQ register decode
package gpio_pkg;

    // Offsets of the GPIO output register block sharing this address space
    localparam int unsigned GPIO_OUT_OFF      = 32'h0;
    localparam int unsigned GPIO_OE_OFF       = 32'h4;
    localparam int unsigned GPIO_IN_OFF       = 32'h8;

    localparam int unsigned EDGE_STATE_OFF    = 32'h0;
    localparam int unsigned EDGE_RISE_EN_OFF  = 32'h4;
    localparam int unsigned EDGE_FALL_EN_OFF  = 32'h8;
    localparam int unsigned EDGE_STATUS_OFF   = 32'hC;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_STATE,
        REG_RISE_EN,
        REG_FALL_EN,
        REG_STATUS
    } edge_reg_e;

    // Full-width compare so aliases of mapped offsets decode as unmapped
    function automatic edge_reg_e decode_edge_reg(input logic [31:0] off);
        edge_reg_e r;
        r = REG_NONE;
        if (off == EDGE_STATE_OFF)   r = REG_STATE;
        if (off == EDGE_RISE_EN_OFF) r = REG_RISE_EN;
        if (off == EDGE_FALL_EN_OFF) r = REG_FALL_EN;
        if (off == EDGE_STATUS_OFF)  r = REG_STATUS;
        return r;
    endfunction

endpackage

// File: rtl/gpio_edge_irq_if.sv
// rtl/gpio_edge_irq_if.sv - register bus between CPU and gpio_edge_irq
interface gpio_edge_irq_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
);
    logic                  i_sel;
    logic                  i_we;
    logic [ADDR_WIDTH-1:0] i_addr;
    logic [DATA_WIDTH-1:0] i_wdata;
    logic [DATA_WIDTH-1:0] o_rdata;

    modport master (
        output i_sel, i_we, i_addr, i_wdata,
        input  o_rdata
    );

    modport slave (
        input  i_sel, i_we, i_addr, i_wdata,
        output o_rdata
    );
endinterface

// File: rtl/gpio_debounce_bit.sv
// rtl/gpio_debounce_bit.sv - one pin: two-flop synchronizer, stability counter, debounced level
module gpio_debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_pin,
    output logic o_state,
    output logic o_rise,
    output logic o_fall
);
    import gpio_pkg::*;

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             w_differ;
    logic             w_done;

    assign w_differ = r_sync2 ^ r_state;
    assign w_done   = w_differ && (r_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_state <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_pin;
            r_sync2 <= r_sync1;
            if (!w_differ) begin
                r_cnt <= '0;
            end else if (w_done) begin
                r_state <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Event strobes are valid in the cycle before the edge that commits r_state
    assign o_state = r_state;
    assign o_rise  = w_done &  r_sync2;
    assign o_fall  = w_done & ~r_sync2;

endmodule

// File: rtl/gpio_edge_irq.sv
// rtl/gpio_edge_irq.sv - debounced GPIO edge detector with RW1C status and level interrupt
module gpio_edge_irq #(
    parameter int ADDR_WIDTH      = 4,
    parameter int DATA_WIDTH      = 32,
    parameter int GPIO_WIDTH      = 4,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    gpio_edge_irq_if.slave        bus,
    input  logic [GPIO_WIDTH-1:0] i_pins,
    output logic                  o_irq
);
    import gpio_pkg::*;

    logic [GPIO_WIDTH-1:0] r_rise_en;
    logic [GPIO_WIDTH-1:0] r_fall_en;
    logic [GPIO_WIDTH-1:0] r_status;

    logic [GPIO_WIDTH-1:0] w_state;
    logic [GPIO_WIDTH-1:0] w_rise;
    logic [GPIO_WIDTH-1:0] w_fall;
    logic [GPIO_WIDTH-1:0] w_set;
    logic [GPIO_WIDTH-1:0] w_w1c;
    logic [GPIO_WIDTH-1:0] w_wbits;
    logic [31:0]           w_off;
    edge_reg_e             w_reg;
    logic                  w_rd;
    logic                  w_wr;
    logic                  w_unused_wdata;

    assign w_off   = 32'(bus.i_addr[ADDR_WIDTH-1:0]);
    assign w_reg   = decode_edge_reg(w_off);
    assign w_rd    = bus.i_sel & ~bus.i_we;
    assign w_wr    = bus.i_sel &  bus.i_we;
    assign w_wbits = bus.i_wdata[GPIO_WIDTH-1:0];
    assign w_unused_wdata = |bus.i_wdata[DATA_WIDTH-1:GPIO_WIDTH];

    for (genvar g = 0; g < GPIO_WIDTH; g++) begin : g_pin
        gpio_debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_bit (
            .clk     (clk),
            .reset   (reset),
            .i_pin   (i_pins[g]),
            .o_state (w_state[g]),
            .o_rise  (w_rise[g]),
            .o_fall  (w_fall[g])
        );
    end

    assign w_set = (w_rise & r_rise_en) | (w_fall & r_fall_en);
    assign w_w1c = (w_wr && (w_reg == REG_STATUS)) ? w_wbits : '0;

    // Set is OR-ed after the clear so a coincident event wins over W1C
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rise_en <= '0;
            r_fall_en <= '0;
            r_status  <= '0;
        end else begin
            if (w_wr && (w_reg == REG_RISE_EN)) r_rise_en <= w_wbits;
            if (w_wr && (w_reg == REG_FALL_EN)) r_fall_en <= w_wbits;
            r_status <= (r_status & ~w_w1c) | w_set;
        end
    end

    always_comb begin
        bus.o_rdata = '0;
        if (w_rd) begin
            case (w_reg)
                REG_STATE:   bus.o_rdata = DATA_WIDTH'(w_state);
                REG_RISE_EN: bus.o_rdata = DATA_WIDTH'(r_rise_en);
                REG_FALL_EN: bus.o_rdata = DATA_WIDTH'(r_fall_en);
                REG_STATUS:  bus.o_rdata = DATA_WIDTH'(r_status);
                default:     bus.o_rdata = '0;
            endcase
        end
    end

    assign o_irq = |r_status;

endmodule

// File: tb/tb_gpio_edge_irq.sv
// tb/tb_gpio_edge_irq.sv - randomized and directed checks of gpio_edge_irq against a reference model
module tb_gpio_edge_irq;
    localparam int D  = 4;
    localparam int AW = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] i_pins;
    logic       o_irq;

    gpio_edge_irq_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) bus ();

    gpio_edge_irq #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(32), .GPIO_WIDTH(4), .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus),
        .i_pins (i_pins),
        .o_irq  (o_irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: a pin's debounced level flips once its synchronized copy
    // (pin value from two edges back) has disagreed for D consecutive edges.
    logic [3:0] m_state, m_rise, m_fall, m_status;
    logic [3:0] m_hist [0:7];

    function automatic logic [31:0] m_rdata(input logic sel, input logic we, input logic [AW-1:0] addr);
        if (!sel || we) return 32'h0;
        case (addr)
            8'h00:   return {28'h0, m_state};
            8'h04:   return {28'h0, m_rise};
            8'h08:   return {28'h0, m_fall};
            8'h0C:   return {28'h0, m_status};
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_edge(input logic [3:0] pins, input logic sel, input logic we,
                              input logic [AW-1:0] addr, input logic [31:0] wdata, input logic rst);
        logic [3:0] nstate, rise, fall, set;
        bit         all_diff;
        if (rst) begin
            m_state = 0; m_rise = 0; m_fall = 0; m_status = 0;
            for (int k = 0; k < 8; k++) m_hist[k] = 4'h0;
            return;
        end
        nstate = m_state; rise = 0; fall = 0;
        for (int i = 0; i < 4; i++) begin
            all_diff = 1;
            for (int k = 1; k <= D; k++)
                if (m_hist[k][i] == m_state[i]) all_diff = 0;
            if (all_diff) begin
                nstate[i] = ~m_state[i];
                if (nstate[i]) rise[i] = 1'b1; else fall[i] = 1'b1;
            end
        end
        set = (rise & m_rise) | (fall & m_fall);
        if (sel && we && addr == 8'h0C) m_status = (m_status & ~wdata[3:0]) | set;
        else                            m_status = m_status | set;
        if (sel && we && addr == 8'h04) m_rise = wdata[3:0];
        if (sel && we && addr == 8'h08) m_fall = wdata[3:0];
        m_state = nstate;
        for (int k = 7; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = pins;
    endtask

    task automatic step(input logic [3:0] pins, input logic sel, input logic we,
                        input logic [AW-1:0] addr, input logic [31:0] wdata, input logic rst);
        i_pins = pins; bus.i_sel = sel; bus.i_we = we; bus.i_addr = addr;
        bus.i_wdata = wdata; reset = rst;
        #1;
        check("irq", {31'h0, o_irq}, {31'h0, |m_status});
        check("rdata", bus.o_rdata, m_rdata(sel, we, addr));
        @(posedge clk);
        model_edge(pins, sel, we, addr, wdata, rst);
        @(negedge clk);
    endtask

    task automatic idle(input logic [3:0] p);                       step(p, 0, 0, 8'h00, 32'h0, 0); endtask
    task automatic rd(input logic [3:0] p, input logic [AW-1:0] a); step(p, 1, 0, a, 32'h0, 0);     endtask
    task automatic wr(input logic [3:0] p, input logic [AW-1:0] a, input logic [31:0] d); step(p, 1, 1, a, d, 0); endtask
    task automatic rst(input logic [3:0] p);                        step(p, 0, 0, 8'h00, 32'h0, 1); endtask

    logic [3:0]    rp;
    logic [AW-1:0] ra;
    int            op;

    initial begin
        i_pins = 0; bus.i_sel = 0; bus.i_we = 0; bus.i_addr = 0; bus.i_wdata = 0; reset = 1;
        repeat (2) @(posedge clk);
        model_edge(4'h0, 0, 0, 8'h00, 32'h0, 1);
        @(negedge clk);

        // Stable level latency
        rst(4'h0);
        for (int k = 1; k <= 7; k++) begin
            rd(4'h5, 8'h00);
            if (k == 5) check("state_edge5", bus.o_rdata, 32'h0);
            if (k == 6) check("state_edge6", bus.o_rdata, 32'h5);
        end

        // Rising-edge interrupt and W1C
        rst(4'h0);
        wr(4'h0, 8'h04, 32'h1);
        for (int k = 1; k <= 6; k++) begin
            idle(4'h1);
            if (k == 5) check("irq_pre", {31'h0, o_irq}, 32'h0);
            if (k == 6) check("irq_rise", {31'h0, o_irq}, 32'h1);
        end
        rd(4'h1, 8'h0C);
        check("status_rise", bus.o_rdata, 32'h1);
        wr(4'h1, 8'h0C, 32'h1);
        check("irq_cleared", {31'h0, o_irq}, 32'h0);
        rd(4'h1, 8'h0C);
        check("status_cleared", bus.o_rdata, 32'h0);

        // Set and W1C colliding on the same edge
        repeat (8) idle(4'h0);
        repeat (6) idle(4'h1);
        repeat (8) idle(4'h0);
        repeat (5) idle(4'h1);
        wr(4'h1, 8'h0C, 32'h1);
        check("collide_irq", {31'h0, o_irq}, 32'h1);
        rd(4'h1, 8'h0C);
        check("collide_status", bus.o_rdata, 32'h1);

        // Glitch rejection and falling-edge interrupt
        rst(4'h0);
        wr(4'h0, 8'h08, 32'h2);
        repeat (3) idle(4'h2);
        repeat (12) idle(4'h0);
        rd(4'h0, 8'h0C);
        check("glitch_status", bus.o_rdata, 32'h0);
        rd(4'h0, 8'h00);
        check("glitch_state", bus.o_rdata, 32'h0);
        repeat (10) idle(4'h2);
        rd(4'h0, 8'h0C);
        check("fall_pre", bus.o_rdata, 32'h0);
        repeat (8) idle(4'h0);
        rd(4'h0, 8'h0C);
        check("fall_status", bus.o_rdata, 32'h2);

        // Reset in mid-debounce, pin high across release
        rst(4'h0);
        repeat (4) idle(4'h8);
        rst(4'h8);
        check("rst_mid_status", {31'h0, o_irq}, 32'h0);
        wr(4'h8, 8'h04, 32'h8);
        for (int k = 2; k <= 6; k++) begin
            rd(4'h8, 8'h00);
            if (k == 5) check("rst_state5", bus.o_rdata, 32'h0);
            if (k == 6) check("rst_state6", bus.o_rdata, 32'h8);
        end
        check("rst_release_irq", {31'h0, o_irq}, 32'h1);

        // Read gating, unmapped offset, write masking
        step(4'h8, 0, 0, 8'h04, 32'h0, 0);
        check("rd_nosel", bus.o_rdata, 32'h0);
        rd(4'h8, 8'h10);
        check("rd_unmapped", bus.o_rdata, 32'h0);
        wr(4'h8, 8'h04, 32'hFFFF_FFFF);
        rd(4'h8, 8'h04);
        check("rise_en_mask", bus.o_rdata, 32'h0000_000F);

        // Randomized traffic
        rp = 4'h0;
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, 5) == 0) rp[i] = ~rp[i];
            op = $urandom_range(0, 9);
            case ($urandom_range(0, 5))
                0:       ra = 8'h00;
                1:       ra = 8'h04;
                2:       ra = 8'h08;
                3, 4:    ra = 8'h0C;
                default: ra = AW'($urandom_range(0, 255));
            endcase
            if ($urandom_range(0, 149) == 0) rst(rp);
            else if (op < 4)                 idle(rp);
            else if (op < 7)                 rd(rp, ra);
            else                             wr(rp, ra, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
